// File: rtl/coupling_pkg.sv
// Shared definitions for the coupling-cell phase meter: result field layout and FSM states.
package coupling_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Flag bit positions, counted upward from the top of the CNT_W-bit delta field
  localparam int RES_LEAD    = 0;
  localparam int RES_ANTI    = 1;
  localparam int RES_TIMEOUT = 2;

  function automatic int res_width(input int cnt_w);
    return cnt_w + 3;
  endfunction

endpackage

// File: rtl/phase_result_fifo.sv
// Synchronous result FIFO; wrap-bit pointers, pop frees a slot for a same-cycle push when full.
module phase_result_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // Storage is not reset; the empty flag masks whatever it holds
  assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/coupling_phase_meter.sv
// Far-end reader of a coupling wavefront line: timestamps sin/cin edges and queues signed
// lead/lag, polarity agreement and timeout per wavefront pair.
module coupling_phase_meter
  import coupling_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int TIMEOUT     = 4095,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sin,
  input  logic             cin,
  input  logic             clr_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W+2:0] res_data,
  output logic             overflow,
  output logic             busy
);

  localparam int              RES_W = res_width(CNT_W);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync_s;
  logic [SYNC_STAGES-1:0] r_sync_c;
  logic                   r_hist_s;
  logic                   r_hist_c;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_lead_cin;
  logic                   r_lead_pol;
  logic                   r_ovf;

  logic             w_e_s, w_e_c, w_p_s, w_p_c;
  logic             w_fol_e, w_fol_p, w_ldr_e, w_ldr_p;
  logic             w_push, w_pop, w_full, w_empty, w_drop;
  logic [RES_W-1:0] w_push_data;

  // Stage: synchronizers and edge history (both lines see identical latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_s <= '0;
      r_sync_c <= '0;
      r_hist_s <= 1'b0;
      r_hist_c <= 1'b0;
    end else begin
      r_sync_s <= {r_sync_s[SYNC_STAGES-2:0], sin};
      r_sync_c <= {r_sync_c[SYNC_STAGES-2:0], cin};
      r_hist_s <= r_sync_s[SYNC_STAGES-1];
      r_hist_c <= r_sync_c[SYNC_STAGES-1];
    end
  end

  assign w_p_s   = r_sync_s[SYNC_STAGES-1];
  assign w_p_c   = r_sync_c[SYNC_STAGES-1];
  assign w_e_s   = w_p_s ^ r_hist_s;
  assign w_e_c   = w_p_c ^ r_hist_c;
  assign w_fol_e = r_lead_cin ? w_e_s : w_e_c;
  assign w_fol_p = r_lead_cin ? w_p_s : w_p_c;
  assign w_ldr_e = r_lead_cin ? w_e_c : w_e_s;
  assign w_ldr_p = r_lead_cin ? w_p_c : w_p_s;

  // Stage: decide whether this cycle closes a measurement
  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (enable) begin
      if (r_state == IDLE) begin
        if (w_e_s && w_e_c) begin
          w_push                          = 1'b1;
          w_push_data[CNT_W+RES_ANTI]     = w_p_s ^ w_p_c;
        end
      end else if (w_fol_e) begin
        w_push                          = 1'b1;
        w_push_data[CNT_W-1:0]          = r_cnt;
        w_push_data[CNT_W+RES_LEAD]     = r_lead_cin;
        w_push_data[CNT_W+RES_ANTI]     = w_fol_p ^ r_lead_pol;
      end else if (r_cnt == TMO) begin
        w_push                          = 1'b1;
        w_push_data[CNT_W-1:0]          = TMO;
        w_push_data[CNT_W+RES_LEAD]     = r_lead_cin;
        w_push_data[CNT_W+RES_TIMEOUT]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lead_cin <= 1'b0;
      r_lead_pol <= 1'b0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_e_s ^ w_e_c) begin
            r_state    <= WAIT;
            r_lead_cin <= w_e_c;
            r_lead_pol <= w_e_c ? w_p_c : w_p_s;
            r_cnt      <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (w_fol_e || (r_cnt == TMO)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_ldr_e) begin
            r_lead_pol <= w_ldr_p;
            r_cnt      <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage: result queue and sticky overflow (a drop beats a same-cycle clear)
  assign w_pop  = res_ready & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  phase_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (res_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign res_valid = ~w_empty;
  assign overflow  = r_ovf;
  assign busy      = (r_state != IDLE);

endmodule
